// File: rtl/button_array_controller.sv
// Per-channel button synchroniser, debouncer and edge-event generator (press, release, click, long).
// Define BTN_AUTO_REPEAT_EN to re-emit o_press every REPEAT_CNT cycles after a long press.

module button_array_controller #(
  parameter int NUM_BTN    = 4,
  parameter int DEBOUNCE   = 1_000_000,
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_BTN-1:0] i_button,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_click,
  output logic [NUM_BTN-1:0] o_long
);

  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CNT - 2);
  localparam bit PARAMS_OK = (NUM_BTN >= 1) && (DEBOUNCE >= 2) &&
                             (LONG_CNT > DEBOUNCE) && (REPEAT_CNT >= 2);
`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
`endif

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PUSHED, RELEASE_WAIT} state_t;

  if (!PARAMS_OK) begin : g_param_check
    $error("button_array_controller: illegal parameter combination");
  end

  genvar gi;
  for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    logic [1:0]        sync_reg;
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              long_flag_reg, long_flag_next;
    logic              level_reg, level_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              click_reg, click_next;
    logic              long_reg, long_next;
    logic              s;
`ifdef BTN_AUTO_REPEAT_EN
    logic [REP_W-1:0]  rep_reg, rep_next;
`endif

    assign s = sync_reg[1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sync_reg      <= '0;
        state_reg     <= RELEASED;
        cnt_reg       <= '0;
        hold_reg      <= '0;
        long_flag_reg <= 1'b0;
        level_reg     <= 1'b0;
        press_reg     <= 1'b0;
        release_reg   <= 1'b0;
        click_reg     <= 1'b0;
        long_reg      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_reg       <= '0;
`endif
      end else begin
        sync_reg      <= {sync_reg[0], i_button[gi]};
        state_reg     <= state_next;
        cnt_reg       <= cnt_next;
        hold_reg      <= hold_next;
        long_flag_reg <= long_flag_next;
        level_reg     <= level_next;
        press_reg     <= press_next;
        release_reg   <= release_next;
        click_reg     <= click_next;
        long_reg      <= long_next;
`ifdef BTN_AUTO_REPEAT_EN
        rep_reg       <= rep_next;
`endif
      end
    end

    always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      hold_next      = hold_reg;
      long_flag_next = long_flag_reg;
      level_next     = level_reg;
      press_next     = 1'b0;
      release_next   = 1'b0;
      click_next     = 1'b0;
      long_next      = 1'b0;
      case (state_reg)
        RELEASED: begin
          if (s) begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_W'(1);
          end else begin
            cnt_next   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_next = RELEASED;
            cnt_next   = '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next     = PUSHED;
            cnt_next       = '0;
            level_next     = 1'b1;
            press_next     = 1'b1;
            hold_next      = '0;
            long_flag_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        PUSHED: begin
          if (!s) begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_W'(1);
          end else begin
            if (hold_reg != HOLD_LAST) hold_next = hold_reg + HOLD_W'(1);
            // Fires on the edge that moves hold_cnt onto its saturation value.
            if (hold_reg == HOLD_PRE && !long_flag_reg) begin
              long_next      = 1'b1;
              long_flag_next = 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_next = PUSHED;
            cnt_next   = '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next   = RELEASED;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
            click_next   = !long_flag_reg;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = RELEASED;
          cnt_next   = '0;
        end
      endcase
`ifdef BTN_AUTO_REPEAT_EN
      rep_next = rep_reg;
      if ((state_reg == PUSHED || state_reg == RELEASE_WAIT) && long_flag_reg) begin
        if (rep_reg == REP_LAST) begin
          rep_next   = '0;
          press_next = 1'b1;
        end else begin
          rep_next = rep_reg + REP_W'(1);
        end
      end
      if (state_next == RELEASED) rep_next = '0;
`endif
    end

    assign o_level[gi]   = level_reg;
    assign o_press[gi]   = press_reg;
    assign o_release[gi] = release_reg;
    assign o_click[gi]   = click_reg;
    assign o_long[gi]    = long_reg;
  end

endmodule

// File: tb/tb_button_array_controller.sv
// Bench for button_array_controller: table-driven channel scenarios plus reset/simultaneous sequences,
// with expected events queued at stimulus time and compared every cycle on the falling edge.

module tb_button_array_controller;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic [N-1:0] i_button;
  logic [N-1:0] o_level, o_press, o_release, o_click, o_long;

  button_array_controller #(
    .NUM_BTN(N), .DEBOUNCE(DEB), .LONG_CNT(LNG), .REPEAT_CNT(REP)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_button(i_button),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_click(o_click), .o_long(o_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] press, rel, click, lng, set, clr;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    int          ch;
    logic [63:0] pat;
    int          len;
    int          p;
    int          l;
    int          r;
    bit          c;
  } row_t;
  row_t rows[9];

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_level = '0;

  task automatic check4(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] k, input logic [N-1:0] l,
                         input logic [N-1:0] st, input logic [N-1:0] cl);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.click = k; e.lng = l; e.set = st; e.clr = cl;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output bit is compared every cycle; absent events mean 0.
  always @(negedge clk) begin
    logic [N-1:0] ep, er, ec, el, ls, lc;
    ep = '0; er = '0; ec = '0; el = '0; ls = '0; lc = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ev_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_event cyc=%0d actual=unconsumed required=cycle %0d", cyc, e.cyc);
      end else begin
        ep |= e.press; er |= e.rel; ec |= e.click; el |= e.lng; ls |= e.set; lc |= e.clr;
      end
    end
    if (!i_reset_n) exp_level = '0;
    exp_level = (exp_level | ls) & ~lc;
    check4("o_press", o_press, ep);
    check4("o_release", o_release, er);
    check4("o_click", o_click, ec);
    check4("o_long", o_long, el);
    check4("o_level", o_level, exp_level);
  end

  task automatic apply_row(input row_t r);
    int e0;
    logic [N-1:0] m;
    e0 = cyc + 1;
    m = '0;
    m[r.ch] = 1'b1;
    if (r.p >= 0) push_ev(e0 + r.p, m, '0, '0, '0, m, '0);
    if (r.l >= 0) begin
      push_ev(e0 + r.l, '0, '0, '0, m, '0, '0);
`ifdef BTN_AUTO_REPEAT_EN
      for (int t = r.l + REP; t <= r.r; t += REP) push_ev(e0 + t, m, '0, '0, '0, '0, '0);
`endif
    end
    if (r.r >= 0) push_ev(e0 + r.r, '0, m, r.c ? m : '0, '0, '0, m);
    for (int i = 0; i < r.len; i++) begin
      i_button[r.ch] = r.pat[i];
      step();
    end
    i_button[r.ch] = 1'b0;
    repeat (14) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL row_drained ch=%0d actual=%0d pending required=0", r.ch, sb.size());
    end
    $display("row ch=%0d len=%0d done at cyc=%0d", r.ch, r.len, cyc);
  endtask

  initial begin
    int m;
    // {ch, raw pattern (LSB first), length, press, long, release offsets from first sample edge, click}
    rows[0] = '{0, 64'hFF,           8,  5, -1, 13, 1'b1};
    rows[1] = '{1, 64'hFB,           8,  8, -1, 13, 1'b1};
    rows[2] = '{1, 64'h7,            3, -1, -1, -1, 1'b0};
    rows[3] = '{2, 64'h3FF,         10,  5, -1, 15, 1'b1};
    rows[4] = '{3, 64'hFF_FFFF_FFFF, 40, 5, 24, 45, 1'b0};
    rows[5] = '{0, 64'h13FF,        13,  5, -1, 18, 1'b1};
    rows[6] = '{2, 64'hF,            4,  5, -1,  9, 1'b1};
    rows[7] = '{3, 64'h3F_FFFF,     22,  5, -1, 27, 1'b1};
    rows[8] = '{3, 64'h7F_FFFF,     23,  5, 24, 28, 1'b0};

    i_reset_n = 1'b0;
    i_button  = '0;
    repeat (3) step();
    check4("reset_level", o_level, '0);
    check4("reset_press", o_press, '0);
    i_reset_n = 1'b1;

    // Latency: raw sampled high at edge 10 -> press/level after edge 15.
    while (cyc < 9) step();
    push_ev(15, 4'b0001, '0, '0, '0, 4'b0001, '0);
    push_ev(25, '0, 4'b0001, 4'b0001, '0, '0, 4'b0001);
    i_button[0] = 1'b1;
    while (cyc < 14) step();
    check4("latency_level_before", o_level, 4'b0000);
    step();
    check4("latency_press", o_press, 4'b0001);
    check4("latency_level", o_level, 4'b0001);
    step();
    check4("latency_press_width", o_press, 4'b0000);
    while (cyc < 19) step();
    i_button[0] = 1'b0;
    repeat (14) step();
    $display("latency sequence done at cyc=%0d", cyc);

    for (int i = 0; i < 9; i++) apply_row(rows[i]);

    // All channels pressed on the same edge.
    m = cyc + 1;
    push_ev(m + 5, 4'hF, '0, '0, '0, 4'hF, '0);
    push_ev(m + 13, '0, 4'hF, 4'hF, '0, '0, 4'hF);
    i_button = 4'hF;
    repeat (8) step();
    i_button = '0;
    repeat (14) step();
    $display("simultaneous press done at cyc=%0d", cyc);

    // Reset asserted mid-PRESS_WAIT with buttons held through deassertion.
    i_button = 4'hF;
    repeat (4) step();
    #1 i_reset_n = 1'b0;
    #1;
    check4("rst_pw_level", o_level, '0);
    check4("rst_pw_press", o_press, '0);
    repeat (2) step();
    i_reset_n = 1'b1;
    m = cyc;
    push_ev(m + 6, 4'hF, '0, '0, '0, 4'hF, '0);
    while (cyc < m + 8) step();
    check4("fresh_press_level", o_level, 4'hF);

    // Reset while PUSHED clears the level without waiting for a clock edge.
    #1 i_reset_n = 1'b0;
    #1;
    check4("rst_pushed_level", o_level, '0);
    i_button = '0;
    repeat (2) step();
    i_reset_n = 1'b1;
    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_drained actual=%0d pending required=0", sb.size());
    end
    $display("reset sequences done at cyc=%0d", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_array_controller.md
Name: button_array_controller

Overview:
- Parametrised multi-channel successor to the single-button debouncer: N independent button channels, each with input synchroniser, symmetric press/release debounce, and edge-event outputs.
- Adds press, release, short-click and long-press events plus a stable debounced level per channel.
- Sits between board push-buttons and the FSM/control logic; all outputs are registered.

Parameters:
- NUM_BTN, 4, number of independent button channels (>=1).
- DEBOUNCE, 1_000_000, consecutive stable synchronised samples required to accept a level change (>=2).
- LONG_CNT, 50_000_000, cycles in PUSHED before o_long fires (>DEBOUNCE).
- REPEAT_CNT, 10_000_000, auto-repeat period in cycles; used only with BTN_AUTO_REPEAT_EN (>=2).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_button  input  NUM_BTN  raw asynchronous button inputs, 1 = pushed.
- o_level  output  NUM_BTN  debounced level per channel.
- o_press  output  NUM_BTN  1-cycle pulse on accepted press.
- o_release  output  NUM_BTN  1-cycle pulse on accepted release.
- o_click  output  NUM_BTN  1-cycle pulse on accepted release when no long press fired during that hold.
- o_long  output  NUM_BTN  1-cycle pulse once per hold when held LONG_CNT cycles.

Behaviour:
- Reset (i_reset_n=0, async): all outputs 0, sync flops 0, counters 0, every channel in RELEASED, long flag 0.
- Per channel: 2-flop synchroniser; s = second flop. Channels fully independent; no cross-channel priority.
- FSM states: RELEASED, PRESS_WAIT, PUSHED, RELEASE_WAIT.
- RELEASED: s=1 -> PRESS_WAIT, cnt=1. Else stay, cnt=0.
- PRESS_WAIT: s=0 -> RELEASED, cnt=0 (bounce rejected, no event). s=1 and cnt==DEBOUNCE-1 -> PUSHED, o_level<=1, o_press pulse, hold_cnt=0, long flag=0. Else cnt++.
- PUSHED: s=0 -> RELEASE_WAIT, cnt=1. Else hold_cnt++ saturating at LONG_CNT-1; at the edge hold_cnt reaches LONG_CNT-1 (first time only): o_long pulse, long flag=1.
- RELEASE_WAIT: s=1 -> PUSHED, cnt=0, hold_cnt continues (glitch does not restart hold). s=0 and cnt==DEBOUNCE-1 -> RELEASED, o_level<=0, o_release pulse, o_click pulse iff long flag=0. Else cnt++.
- Latency: raw sampled high at edge e0 with no bounce -> o_press/o_level rise after edge e0+1+DEBOUNCE. Release symmetric.
- Pulses are exactly one cycle; o_click and o_release coincide; o_long never coincides with o_press.
- Counter widths: $clog2(DEBOUNCE+1) for cnt, $clog2(LONG_CNT+1) for hold_cnt; no wrap (hold_cnt saturates).
- Reset mid-operation: channel returns to RELEASED with no event; a button held through reset deassertion is debounced as a fresh press.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: after o_long fires, while PUSHED/RELEASE_WAIT, a rep_cnt re-emits o_press every REPEAT_CNT cycles (first repeat REPEAT_CNT cycles after o_long); rep_cnt cleared on entry to RELEASED or reset; o_click still suppressed.
- Undefined: exactly one o_press per accepted press; no rep_cnt logic synthesised.

Test Plan:
- NUM_BTN=4, DEBOUNCE=4, LONG_CNT=20: ch0 raw high at edge 10 steady -> o_press[0] and o_level[0] high after edge 15; o_press one cycle; other channels 0.
- Bounce: ch1 raw 1,1,0,1,1,1,1,1 -> no event until 4 consecutive s=1; only one o_press[1]; a 3-cycle glitch never produces o_press.
- Short click: ch2 held 10 cycles then released steady -> o_release[2] and o_click[2] same cycle, o_long[2] never.
- Long press: ch3 held 40 cycles -> o_long[3] exactly once, LONG_CNT-1 edges after press accept; release gives o_release[3], no o_click[3].
- Simultaneous: all channels pressed same edge -> all o_press bits high same cycle; assert i_reset_n=0 mid-PRESS_WAIT -> outputs 0 immediately, no event after reset release until a full new debounce.
- With BTN_AUTO_REPEAT_EN, REPEAT_CNT=5: ch0 held 40 cycles -> o_long then o_press every 5 cycles until release.
